// File: rtl/key_conditioner.sv
// Push-button conditioner: 2-flop sync, counter debounce FSM, level plus press/release/long pulses per key.
// Latency: key_n edge to pressed/press_pulse is 2 + DEBOUNCE_CYCLES clocks; release is symmetric.
// Backpressure: none; all outputs are registered status/pulses that downstream must sample every cycle.
module key_conditioner #(
    parameter int N_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int CNT_W           = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] pressed,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse
);

    typedef enum logic [1:0] {
        RELEASED,
        WAIT_PRESS,
        PRESSED,
        WAIT_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    // LONG_CYCLES == 0 disables the hold timer entirely, so the compare value is irrelevant then.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'((LONG_CYCLES > 0) ? (LONG_CYCLES - 1) : 0);
    localparam bit               LONG_EN   = (LONG_CYCLES != 0);

    logic [N_KEYS-1:0] sync1_q, sync1_d;
    logic [N_KEYS-1:0] sync2_q, sync2_d;

    // Two-stage synchronizer chain for the asynchronous key inputs.
    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
    end

    // Synchronizer flops reset to released (high).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        state_t           state_q, state_d;
        logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
        logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
        logic             long_done_q, long_done_d;
        logic             pressed_q, pressed_d;
        logic             press_pulse_q, press_pulse_d;
        logic             release_pulse_q, release_pulse_d;
        logic             long_pulse_q, long_pulse_d;
        logic             s;

        // s = 1 means the synchronized key is pressed.
        assign s = ~sync2_q[g];

        // Debounce FSM plus hold timer; pulses default low so they last one cycle.
        always_comb begin
            state_d         = state_q;
            deb_cnt_d       = deb_cnt_q;
            hold_cnt_d      = hold_cnt_q;
            long_done_d     = long_done_q;
            pressed_d       = pressed_q;
            press_pulse_d   = 1'b0;
            release_pulse_d = 1'b0;
            long_pulse_d    = 1'b0;

            case (state_q)
                RELEASED: begin
                    if (s) begin
                        state_d   = WAIT_PRESS;
                        deb_cnt_d = '0;
                    end
                end
                WAIT_PRESS: begin
                    if (!s) begin
                        state_d = RELEASED;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_d       = PRESSED;
                        press_pulse_d = 1'b1;
                        pressed_d     = 1'b1;
                        hold_cnt_d    = '0;
                        long_done_d   = 1'b0;
                    end else begin
                        deb_cnt_d = deb_cnt_q + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state_d   = WAIT_RELEASE;
                        deb_cnt_d = '0;
                    end
                end
                WAIT_RELEASE: begin
                    if (s) begin
                        // Release bounce: back to held without disturbing the hold timer.
                        state_d = PRESSED;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_d         = RELEASED;
                        release_pulse_d = 1'b1;
                        pressed_d       = 1'b0;
                    end else begin
                        deb_cnt_d = deb_cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = RELEASED;
            endcase

            // Hold timer runs while the key is accepted as held; freezes after firing once.
            if (LONG_EN && (state_q == PRESSED || state_q == WAIT_RELEASE) && !long_done_q) begin
                if (hold_cnt_q == LONG_LAST) begin
                    long_pulse_d = 1'b1;
                    long_done_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
        end

        // Per-key state and registered outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q         <= RELEASED;
                deb_cnt_q       <= '0;
                hold_cnt_q      <= '0;
                long_done_q     <= 1'b0;
                pressed_q       <= 1'b0;
                press_pulse_q   <= 1'b0;
                release_pulse_q <= 1'b0;
                long_pulse_q    <= 1'b0;
            end else begin
                state_q         <= state_d;
                deb_cnt_q       <= deb_cnt_d;
                hold_cnt_q      <= hold_cnt_d;
                long_done_q     <= long_done_d;
                pressed_q       <= pressed_d;
                press_pulse_q   <= press_pulse_d;
                release_pulse_q <= release_pulse_d;
                long_pulse_q    <= long_pulse_d;
            end
        end

        assign pressed[g]       = pressed_q;
        assign press_pulse[g]   = press_pulse_q;
        assign release_pulse[g] = release_pulse_q;
        assign long_pulse[g]    = long_pulse_q;
    end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
Front-end conditioning stage for the board push-buttons; sits directly upstream of the LED blink/period logic and drives its reset and change inputs. Per key it provides:
- two-flop synchronization of the raw active-low KEY input;
- counter-based debounce through a four-state FSM;
- a clean level, plus single-cycle press, release and long-press pulses.
All keys are independent instances of the same per-key logic inside one module.

Parameters:
N_KEYS, 2, number of independent keys conditioned.
DEBOUNCE_CYCLES, 500000, stable cycles required to accept a level change (10 ms at 50 MHz); must be >= 1.
LONG_CYCLES, 50000000, hold cycles after an accepted press before long_pulse fires (1 s at 50 MHz); 0 disables long_pulse; otherwise must be > DEBOUNCE_CYCLES.
CNT_W, 26, width of the debounce and hold counters; must hold max(DEBOUNCE_CYCLES, LONG_CYCLES).

Ports:
clk  in  1  system clock (CLOCK_50)
rst  in  1  synchronous, active-high reset
key_n  in  N_KEYS  raw asynchronous key inputs, active-low (0 = pressed)
pressed  out  N_KEYS  debounced level, 1 = key held
press_pulse  out  N_KEYS  one-cycle pulse on accepted press
release_pulse  out  N_KEYS  one-cycle pulse on accepted release
long_pulse  out  N_KEYS  one-cycle pulse once per press after LONG_CYCLES of hold

Behaviour:
- Reset: rst is synchronous, active-high; clock clk.
  - Sync flops reset to 1 (released).
  - FSM state goes to RELEASED; both counters go to 0; long_done goes to 0.
  - All outputs reset to 0.
- Sync: two flops per key. The FSM sees s = ~ff2, where s = 1 means pressed.
- FSM states (per key): RELEASED, WAIT_PRESS, PRESSED, WAIT_RELEASE. All outputs are registered.
- RELEASED:
  - s = 1 -> WAIT_PRESS, deb_cnt <= 0.
- WAIT_PRESS:
  - s = 0 -> RELEASED (bounce rejected, no pulse).
  - Else deb_cnt increments.
  - When s = 1 and deb_cnt == DEBOUNCE_CYCLES-1 -> PRESSED. Same edge: press_pulse <= 1, pressed <= 1, hold_cnt <= 0, long_done <= 0.
- PRESSED:
  - s = 0 -> WAIT_RELEASE, deb_cnt <= 0.
- WAIT_RELEASE:
  - s = 1 -> PRESSED (release bounce rejected). pressed stays 1, no pulse, hold_cnt not cleared.
  - Else deb_cnt increments.
  - When s = 0 and deb_cnt == DEBOUNCE_CYCLES-1 -> RELEASED. Same edge: release_pulse <= 1, pressed <= 0.
- Hold timer:
  - hold_cnt increments every cycle in PRESSED and WAIT_RELEASE while long_done = 0.
  - On the edge where hold_cnt == LONG_CYCLES-1: long_pulse <= 1, long_done <= 1, hold_cnt frozen.
  - Never fires twice per accepted press.
  - If LONG_CYCLES = 0, long_pulse stays 0.
- Pulses: press_pulse, release_pulse and long_pulse are high for exactly one cycle, then 0 the next cycle.
  - long_pulse and release_pulse may assert in the same cycle if both conditions coincide.
- Latency: raw key_n falls before edge k and stays low. press_pulse and pressed go high after edge k+2+DEBOUNCE_CYCLES. Release latency is symmetric.
- Keys: fully independent, with no cross-key interaction; simultaneous presses are each reported.
- Reset mid-operation: any state goes to RELEASED.
  - A key held through reset deassertion is treated as a fresh press and goes through the full debounce.
  - No release_pulse is emitted for the aborted press.
- Counter widths: deb_cnt and hold_cnt are unsigned CNT_W bits and never wrap (bounded by the FSM and the freeze).

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, N_KEYS=2.
- Clean press: key_n[0] low at edge 10, held -> pressed[0] and press_pulse[0] high after edge 16; press_pulse[0] low after edge 17; key 1 outputs all 0.
- Bounce reject: key_n[0] low 3 cycles, high 1, low 3, high -> no press_pulse, pressed[0] stays 0.
- Release with bounce: key 0 held 10 cycles after accept, then key_n high 2 cycles, low 1, high steady -> exactly one release_pulse, 4 cycles after the final steady high is seen; pressed stays 1 through the bounce.
- Long press: hold key 0 for 40 cycles after accept -> long_pulse[0] exactly once, 20 cycles after press_pulse; no second pulse; release_pulse on release.
- Simultaneous keys: both key_n low on the same edge -> press_pulse[1:0] = 2'b11 in the same cycle.
- Reset mid-press: rst for 1 cycle while key 0 is in PRESSED with key held -> all outputs 0 after reset; new press_pulse 6 cycles after rst deasserts; no release_pulse.
